// File: rtl/g1_table_writer.sv
// g1_table_writer: insert/delete engine driving the write port of one G1 rule table,
// allocating slots from an occupancy bitmap and packing rules into 171-bit entries.
module g1_table_writer #(
    parameter int TABLE_ENTRY_SIZE = 154,
    parameter int INIT_USED        = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_op,
    input  logic [10:0]  req_index,
    input  logic [31:0]  req_srcIP,
    input  logic [5:0]   req_srcLen,
    input  logic [31:0]  req_dstIP,
    input  logic [5:0]   req_dstLen,
    input  logic [15:0]  req_srcPort_lo,
    input  logic [15:0]  req_srcPort_hi,
    input  logic [15:0]  req_dstPort_lo,
    input  logic [15:0]  req_dstPort_hi,
    input  logic [7:0]   req_proto,
    input  logic         req_proto_any,
    input  logic [10:0]  req_ruleID,
    input  logic [10:0]  req_next,
    output logic         we,
    output logic [170:0] din,
    output logic [10:0]  wr_index,
    output logic         rsp_valid,
    output logic [1:0]   rsp_status,
    output logic [10:0]  rsp_index,
    output logic [10:0]  used_count
);
    localparam int N = TABLE_ENTRY_SIZE + 1;
    localparam logic [10:0] LAST = 11'(TABLE_ENTRY_SIZE);
    localparam logic [10:0] PTR0 = (INIT_USED == N) ? 11'd0 : 11'(INIT_USED);

    function automatic logic [N-1:0] init_map();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = (i < INIT_USED);
        return m;
    endfunction
    localparam logic [N-1:0] INIT_MAP = init_map();

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, RESP} state_t;

    state_t         state_q, state_d;
    logic [10:0]    ptr_q, ptr_d, cnt_q, cnt_d, idx_q, idx_d, used_q, used_d;
    logic [10:0]    wr_index_q, wr_index_d, rsp_index_q, rsp_index_d;
    logic           op_q, op_d, we_q, we_d, rsp_valid_q, rsp_valid_d, ready_q, ready_d;
    logic [170:0]   ent_q, ent_d, din_q, din_d;
    logic [N-1:0]   bitmap_q, bitmap_d;
    logic [1:0]     rsp_status_q, rsp_status_d;
    logic           ptr_used, del_used;

    assign ptr_used = |(bitmap_q & (N'(1) << ptr_q));
    assign del_used = |(bitmap_q & (N'(1) << req_index));

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        op_d         = op_q;
        ent_d        = ent_q;
        bitmap_d     = bitmap_q;
        used_d       = used_q;
        din_d        = din_q;
        wr_index_d   = wr_index_q;
        rsp_status_d = rsp_status_q;
        rsp_index_d  = rsp_index_q;
        case (state_q)
            IDLE: if (req_valid && ready_q) begin
                op_d  = req_op;
                idx_d = req_index;
                cnt_d = '0;
                ent_d = {req_next, req_ruleID, req_proto_any, req_proto,
                         req_dstPort_lo, req_dstPort_hi, req_srcPort_lo, req_srcPort_hi,
                         req_dstLen, req_dstIP, req_srcLen, req_srcIP};
                if (!req_op) state_d = SCAN;
                else if (req_index <= LAST && del_used) state_d = WRITE;
                else begin
                    state_d      = RESP;
                    rsp_status_d = 2'b10;
                    rsp_index_d  = '0;
                end
            end
            SCAN: if (!ptr_used) begin
                idx_d   = ptr_q;
                state_d = WRITE;
            end else begin
                // A full sweep advances ptr N times, landing back where the scan began.
                ptr_d = (ptr_q == LAST) ? 11'd0 : ptr_q + 11'd1;
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == LAST) begin
                    state_d      = RESP;
                    rsp_status_d = 2'b01;
                    rsp_index_d  = '0;
                end
            end
            WRITE: begin
                bitmap_d     = op_q ? bitmap_q & ~(N'(1) << idx_q) : bitmap_q | (N'(1) << idx_q);
                used_d       = op_q ? used_q - 11'd1 : used_q + 11'd1;
                ptr_d        = op_q ? ptr_q : ((idx_q == LAST) ? 11'd0 : idx_q + 11'd1);
                state_d      = RESP;
                rsp_status_d = 2'b00;
                rsp_index_d  = idx_q;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == WRITE && state_q != WRITE) begin
            wr_index_d = idx_d;
            din_d      = op_d ? '0 : ent_d;
        end
        we_d        = (state_d == WRITE);
        rsp_valid_d = (state_d == RESP);
        ready_d     = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= PTR0;
            cnt_q        <= '0;
            idx_q        <= '0;
            op_q         <= 1'b0;
            ent_q        <= '0;
            bitmap_q     <= INIT_MAP;
            used_q       <= 11'(INIT_USED);
            din_q        <= '0;
            wr_index_q   <= '0;
            we_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= '0;
            rsp_index_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            op_q         <= op_d;
            ent_q        <= ent_d;
            bitmap_q     <= bitmap_d;
            used_q       <= used_d;
            din_q        <= din_d;
            wr_index_q   <= wr_index_d;
            we_q         <= we_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_index_q  <= rsp_index_d;
            ready_q      <= ready_d;
        end
    end

    assign req_ready  = ready_q;
    assign we         = we_q;
    assign din        = din_q;
    assign wr_index   = wr_index_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_status_q;
    assign rsp_index  = rsp_index_q;
    assign used_count = used_q;
endmodule
